// File: rtl/spi_host_pkg.sv
// Shared definitions for the SPI register-access host.
//   FRAME_BITS  : bits per SPI frame (command, address, data bytes)
//   CMD_WRITE   : command byte sent for a register write
//   CMD_READ    : command byte sent for a register read
//   state_t     : host FSM states
//   build_frame : assembles the 24-bit MOSI frame from a command
package spi_host_pkg;

    localparam int         FRAME_BITS = 24;
    localparam logic [7:0] CMD_WRITE  = 8'h80;
    localparam logic [7:0] CMD_READ   = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Reads send zeros in the data byte so the slave sees a clean frame.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic       write,
        input logic [7:0] addr,
        input logic [7:0] wdata
    );
        return {(write ? CMD_WRITE : CMD_READ), addr, (write ? wdata : 8'h00)};
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// SCK phase divider for spi_host.
//   clk_i  : system clock
//   nrst_i : asynchronous active-low reset
//   en_i   : high while a frame is shifting; low holds the divider reloaded
//   rise_o : one-cycle strobe, SCK goes high on the next clk_i edge
//   fall_o : one-cycle strobe, SCK goes low on the next clk_i edge
// Each SCK phase (low, then high) lasts CLK_DIV clk_i cycles.
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic nrst_i,
    input  logic en_i,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] div_cnt;
    logic       phase_hi;

    // Down-counter reloads at every phase change, so it never wraps.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            div_cnt  <= RELOAD;
            phase_hi <= 1'b0;
        end else if (!en_i) begin
            div_cnt  <= RELOAD;
            phase_hi <= 1'b0;
        end else if (div_cnt == 8'd0) begin
            div_cnt  <= RELOAD;
            phase_hi <= ~phase_hi;
        end else begin
            div_cnt  <= div_cnt - 8'd1;
        end
    end

    assign rise_o = en_i && (div_cnt == 8'd0) && !phase_hi;
    assign fall_o = en_i && (div_cnt == 8'd0) &&  phase_hi;

endmodule

// File: rtl/spi_host.sv
// SPI mode-0 host issuing 24-bit register read/write frames.
//   clk_i, nrst_i         : system clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   : command handshake (accepted when both high)
//   cmd_write_i           : 1 = write, 0 = read
//   cmd_addr_i/wdata_i    : register address and write data
//   rsp_valid_o           : one-cycle completion pulse
//   rsp_rdata_o           : MISO byte sampled during the data phase
//   busy_o                : frame in progress
//   spi_clk_o/ncs_o/mosi_o, spi_miso_i : SPI bus
module spi_host
    import spi_host_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic       clk_i,
    input  logic       nrst_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       busy_o,
    output logic       spi_clk_o,
    output logic       spi_ncs_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i
);

    localparam logic [4:0] LAST_BIT   = 5'(FRAME_BITS - 1);
    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    state_t                state, state_nxt;
    logic                  armed;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [7:0]            rx_shift;
    logic [4:0]            bit_cnt;
    logic [7:0]            gap_cnt;
    logic                  sck_q;
    logic                  ncs_q;
    logic                  rsp_valid_q;
    logic [7:0]            rsp_rdata_q;
    logic                  shift_en;
    logic                  sck_rise;
    logic                  sck_fall;
    logic                  accept;
    logic                  last_bit;

    assign shift_en = (state == SHIFT);
    assign accept   = cmd_valid_i && cmd_ready_o;
    assign last_bit = sck_fall && (bit_cnt == LAST_BIT);

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk_i  (clk_i),
        .nrst_i (nrst_i),
        .en_i   (shift_en),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)            state_nxt = SHIFT;
            SHIFT:   if (last_bit)          state_nxt = GAP;
            GAP:     if (gap_cnt == 8'd0)   state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // armed keeps ready low until the first edge after reset release.
    always_comb begin
        cmd_ready_o = armed && (state == IDLE);
        busy_o      = (state == SHIFT);
    end

    // MOSI is the top of tx_shift; zeros shift in, so the line rests low
    // between frames. MISO is captured on the SCK-rising edge, and the
    // last eight captures are the data byte.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            armed       <= 1'b0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            gap_cnt     <= '0;
            sck_q       <= 1'b0;
            ncs_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            armed       <= 1'b1;
            rsp_valid_q <= 1'b0;
            if (accept) begin
                tx_shift <= build_frame(cmd_write_i, cmd_addr_i, cmd_wdata_i);
                bit_cnt  <= '0;
                ncs_q    <= 1'b0;
            end
            if (sck_rise) begin
                sck_q    <= 1'b1;
                rx_shift <= {rx_shift[6:0], spi_miso_i};
            end
            if (sck_fall) begin
                sck_q    <= 1'b0;
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                bit_cnt  <= bit_cnt + 5'd1;
            end
            if (last_bit) begin
                ncs_q       <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rx_shift;
                gap_cnt     <= GAP_RELOAD;
            end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt     <= gap_cnt - 8'd1;
            end
        end
    end

    assign spi_clk_o   = sck_q;
    assign spi_ncs_o   = ncs_q;
    assign spi_mosi_o  = tx_shift[FRAME_BITS-1];
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_spi_host.sv
// Self-checking bench for spi_host: directed and random register
// commands against a frame-level model with an SPI slave/monitor.
module tb_spi_host;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 2;
    localparam int BUDGET  = 64 * CLK_DIV + CS_GAP + 16;

    logic       clk_i = 1'b0;
    logic       nrst_i = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic       cmd_write_i = 1'b0;
    logic [7:0] cmd_addr_i = 8'h00;
    logic [7:0] cmd_wdata_i = 8'h00;
    logic       rsp_valid_o;
    logic [7:0] rsp_rdata_o;
    logic       busy_o;
    logic       spi_clk_o;
    logic       spi_ncs_o;
    logic       spi_mosi_o;
    logic       spi_miso_i = 1'b0;

    spi_host #(
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) dut (
        .clk_i       (clk_i),
        .nrst_i      (nrst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .busy_o      (busy_o),
        .spi_clk_o   (spi_clk_o),
        .spi_ncs_o   (spi_ncs_o),
        .spi_mosi_o  (spi_mosi_o),
        .spi_miso_i  (spi_miso_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [23:0] bits;
        int          rises;
        int          low_cyc;
        int          gap;
        bit          sck_low_edges;
        bit          mosi_stable;
        bit          aborted;
    } frame_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          rsp_total = 0;
    int          hi_cnt = 0;
    frame_t      cur;
    frame_t      frame_q[$];
    logic [23:0] slave_word = 24'h0;
    logic        prev_ncs = 1'b1;
    logic        prev_sck = 1'b0;
    logic        prev_mosi = 1'b0;
    logic [4:0]  miso_idx;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor and slave: records each frame as seen on the wires and
    // drives MISO with slave_word, one bit per SCK rise, MSB first.
    always @(negedge clk_i) begin
        if (rsp_valid_o) rsp_total++;
        if (prev_ncs && !spi_ncs_o) begin
            cur = '{default: '0};
            cur.gap = hi_cnt;
            cur.sck_low_edges = (spi_clk_o === 1'b0);
            cur.mosi_stable = 1'b1;
        end
        if (!spi_ncs_o) begin
            hi_cnt = 0;
            cur.low_cyc++;
            if (!prev_sck && spi_clk_o) begin
                cur.bits = {cur.bits[22:0], spi_mosi_o};
                cur.rises++;
            end
            if (prev_sck && spi_clk_o && (spi_mosi_o !== prev_mosi)) cur.mosi_stable = 1'b0;
        end else begin
            hi_cnt++;
            if (!prev_ncs) begin
                if (spi_clk_o !== 1'b0) cur.sck_low_edges = 1'b0;
                cur.aborted = !nrst_i;
                frame_q.push_back(cur);
            end
        end
        if (!spi_ncs_o && cur.rises < 24) begin
            miso_idx = 5'(23 - cur.rises);
            spi_miso_i = slave_word[miso_idx];
        end else begin
            spi_miso_i = 1'b0;
        end
        prev_ncs  = spi_ncs_o;
        prev_sck  = spi_clk_o;
        prev_mosi = spi_mosi_o;
    end

    function automatic logic [23:0] model_frame(input logic wr, input logic [7:0] ad, input logic [7:0] wd);
        return {(wr ? 8'h80 : 8'h00), ad, (wr ? wd : 8'h00)};
    endfunction

    // Presents a command and waits for acceptance; afterwards the inputs
    // are overwritten so a frame depending on them would show it.
    task automatic issue(input logic wr, input logic [7:0] ad, input logic [7:0] wd, input bit keep);
        bit ok;
        ok = 1'b0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = ad;
        cmd_wdata_i = wd;
        for (int i = 0; i < BUDGET; i++) begin
            if (cmd_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        check("accept", 32'(ok), 1);
        @(posedge clk_i);
        #1;
        if (!keep) begin
            cmd_valid_i = 1'b0;
            cmd_addr_i  = 8'h7F;
            cmd_wdata_i = ~wd;
            cmd_write_i = ~wr;
        end
        check("ncs_fall", 32'(spi_ncs_o), 0);
        check("mosi_bit23", 32'(spi_mosi_o), 32'(wr));
        check("busy_high", 32'(busy_o), 1);
        check("ready_low", 32'(cmd_ready_o), 0);
    endtask

    task automatic wait_rsp(input logic [7:0] exp_rd);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < BUDGET; i++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("rsp_seen", 32'(seen), 1);
        check("rsp_rdata", 32'(rsp_rdata_o), 32'(exp_rd));
        check("ncs_at_rsp", 32'(spi_ncs_o), 1);
        check("sck_at_rsp", 32'(spi_clk_o), 0);
        check("busy_at_rsp", 32'(busy_o), 0);
    endtask

    task automatic check_frame(input logic [23:0] exp, input int exp_gap);
        frame_t f;
        check("frame_present", 32'(frame_q.size() > 0), 1);
        if (frame_q.size() > 0) begin
            f = frame_q.pop_front();
            check("mosi_frame", 32'(f.bits), 32'(exp));
            check("sck_rises", f.rises, 24);
            check("ncs_low_cycles", f.low_cyc, 48 * CLK_DIV);
            check("sck_low_at_ncs", 32'(f.sck_low_edges), 1);
            check("mosi_stable_hi", 32'(f.mosi_stable), 1);
            check("not_aborted", 32'(f.aborted), 0);
            if (exp_gap >= 0) check("cs_gap", f.gap, exp_gap);
        end
    endtask

    task automatic run_cmd(input logic wr, input logic [7:0] ad, input logic [7:0] wd,
                           input logic [7:0] sd, input bit poke);
        int rsp0;
        int n;
        slave_word = {16'($urandom), sd};
        @(posedge clk_i);
        #1;
        rsp0 = rsp_total;
        issue(wr, ad, wd, 1'b0);
        if (poke) begin
            // Commands offered while busy must be ignored, not queued.
            repeat (20) begin
                @(negedge clk_i);
                cmd_valid_i = 1'b1;
                cmd_addr_i  = 8'(~ad);
            end
            @(negedge clk_i);
            cmd_valid_i = 1'b0;
        end
        wait_rsp(sd);
        n = 0;
        while (!cmd_ready_o && n < BUDGET) begin
            @(negedge clk_i);
            n++;
        end
        check("ready_after_gap", n, CS_GAP);
        check("rdata_held", 32'(rsp_rdata_o), 32'(sd));
        repeat (3) @(negedge clk_i);
        check("stays_idle", 32'(spi_ncs_o), 1);
        @(posedge clk_i);
        #1;
        check("rsp_pulses", rsp_total - rsp0, 1);
        check_frame(model_frame(wr, ad, wd), -1);
        check("no_extra_frame", frame_q.size(), 0);
    endtask

    initial begin
        logic       wr;
        logic [7:0] ad, wd, sd, a2, d2;
        int         rsp0;
        frame_t     fa;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_ncs", 32'(spi_ncs_o), 1);
        check("rst_sck", 32'(spi_clk_o), 0);
        check("rst_mosi", 32'(spi_mosi_o), 0);
        check("rst_ready", 32'(cmd_ready_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_rdata", 32'(rsp_rdata_o), 0);
        nrst_i = 1'b1;
        #1;
        check("ready_before_edge", 32'(cmd_ready_o), 0);
        @(posedge clk_i);
        #1;
        check("ready_first_edge", 32'(cmd_ready_o), 1);

        // Directed write, read, and input change during a frame
        run_cmd(1'b1, 8'h03, 8'hA5, 8'($urandom), 1'b0);
        run_cmd(1'b0, 8'h01, 8'hFF, 8'h5C, 1'b0);
        run_cmd(1'b1, 8'h03, 8'h3C, 8'hC3, 1'b1);

        // Random commands
        for (int k = 0; k < 6; k++) begin
            wr = 1'($urandom_range(0, 1));
            ad = 8'($urandom);
            wd = 8'($urandom);
            sd = 8'($urandom);
            run_cmd(wr, ad, wd, sd, 1'b0);
        end

        // Back-to-back writes with cmd_valid_i held high
        ad = 8'($urandom); wd = 8'($urandom);
        a2 = 8'($urandom); d2 = 8'($urandom);
        sd = 8'($urandom);
        slave_word = {16'($urandom), sd};
        @(posedge clk_i);
        #1;
        rsp0 = rsp_total;
        issue(1'b1, ad, wd, 1'b1);
        issue(1'b1, a2, d2, 1'b0);
        wait_rsp(sd);
        @(posedge clk_i);
        #1;
        check("b2b_rsp_pulses", rsp_total - rsp0, 2);
        check("b2b_frames", frame_q.size(), 2);
        check_frame(model_frame(1'b1, ad, wd), -1);
        check_frame(model_frame(1'b1, a2, d2), CS_GAP + 1);

        // Reset in the middle of a frame
        repeat (CS_GAP + 2) @(negedge clk_i);
        slave_word = 24'($urandom);
        rsp0 = rsp_total;
        issue(1'b1, 8'h3C, 8'h96, 1'b0);
        for (int i = 0; i < BUDGET; i++) begin
            @(posedge clk_i);
            #1;
            if (cur.rises >= 10) break;
        end
        check("abort_reached_bit10", cur.rises, 10);
        #2;
        nrst_i = 1'b0;
        #1;
        check("abort_ncs", 32'(spi_ncs_o), 1);
        check("abort_sck", 32'(spi_clk_o), 0);
        check("abort_busy", 32'(busy_o), 0);
        check("abort_rsp_valid", 32'(rsp_valid_o), 0);
        repeat (3) @(negedge clk_i);
        nrst_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("abort_no_rsp", rsp_total - rsp0, 0);
        check("abort_frame_logged", frame_q.size(), 1);
        if (frame_q.size() > 0) begin
            fa = frame_q.pop_front();
            check("abort_flag", 32'(fa.aborted), 1);
            check("abort_short", 32'(fa.rises < 24), 1);
        end
        run_cmd(1'b1, 8'h11, 8'h22, 8'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_host.md
SPI_HOST -- requirements
Module: spi_host

Interface
REQ-001 Parameter CLK_DIV, default 4: clk_i cycles per SCK half-period; legal range 2..255.
REQ-002 Parameter CS_GAP, default 2: clk_i cycles with spi_ncs_o high between frames; legal range 1..255.
REQ-003 clk_i  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 nrst_i  in  1  reset, asynchronous assert, active-low.
REQ-005 cmd_valid_i  in  1  command request.
REQ-006 cmd_ready_o  out  1  block can accept a command.
REQ-007 cmd_write_i  in  1  1 = register write, 0 = register read.
REQ-008 cmd_addr_i  in  8  target register address.
REQ-009 cmd_wdata_i  in  8  write data; don't-care for reads.
REQ-010 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-011 rsp_rdata_o  out  8  byte sampled during the data phase.
REQ-012 busy_o  out  1  high from acceptance until rsp_valid_o.
REQ-013 spi_clk_o, spi_ncs_o, spi_mosi_o  out  1 each  SPI master outputs; spi_miso_i  in  1.

Function
REQ-014 SPI mode 0: SCK idles low; MOSI changes only while SCK is low; MISO sampled on the clk_i edge at which spi_clk_o rises.
REQ-015 Frame: 24 bits, MSB first, in the order command byte (0x80 write, 0x00 read), address byte, data byte; MOSI sends 0x00 in the data byte for reads.
REQ-016 A command is accepted when cmd_valid_i && cmd_ready_o; the command fields SHALL be latched on that cycle, and later input changes SHALL NOT affect the frame.
REQ-017 cmd_ready_o is high only in IDLE; commands presented while busy are not accepted and SHALL NOT be queued.
REQ-018 FSM: IDLE -> SHIFT on acceptance; SHIFT -> GAP after the 24th SCK high phase; GAP -> IDLE after CS_GAP cycles.
REQ-019 spi_ncs_o falls on the cycle after acceptance, with MOSI bit 23 valid on that same cycle.
REQ-020 Each bit lasts 2*CLK_DIV clk_i cycles: CLK_DIV with SCK low, then CLK_DIV with SCK high; spi_ncs_o stays low for exactly 48*CLK_DIV cycles.
REQ-021 spi_ncs_o rises on the cycle after the last SCK high phase ends, with SCK low; rsp_valid_o pulses on that same cycle.
REQ-022 rsp_rdata_o SHALL hold the 8 MISO samples of bits 7..0 and remain stable until the next rsp_valid_o; for writes it carries whatever was sampled.
REQ-023 busy_o falls together with the rsp_valid_o pulse; cmd_ready_o rises CS_GAP cycles after spi_ncs_o rises.
REQ-024 Back-to-back: with cmd_valid_i held high, consecutive frames SHALL be separated by exactly CS_GAP+1 cycles of spi_ncs_o high.
REQ-025 The bit counter (5 bits) and the divider counter (8 bits) SHALL NOT wrap within a frame; the divider reloads at every SCK phase change.

Reset
REQ-026 While nrst_i is low: FSM = IDLE, spi_ncs_o = 1, spi_clk_o = 0, spi_mosi_o = 0, cmd_ready_o = 0, busy_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0x00.
REQ-027 cmd_ready_o SHALL rise on the first clk_i edge after nrst_i deasserts.
REQ-028 A reset during a frame SHALL abort it immediately (asynchronously): spi_ncs_o goes high, no rsp_valid_o is produced, and the command is discarded.

Structure
REQ-029 Package spi_host_pkg SHALL hold: FRAME_BITS = 24, CMD_WRITE = 8'h80, CMD_READ = 8'h00, and the FSM state enum (IDLE, SHIFT, GAP).
REQ-030 The divider SHALL be a sub-module, spi_tick_gen, producing one-cycle rise/fall strobes; the shift register and FSM stay in spi_host.

Verification
REQ-031 Write addr 0x03, data 0xA5, CLK_DIV = 4: MOSI carries 0x80,0x03,0xA5; spi_ncs_o low for 192 cycles; one rsp_valid_o pulse.
REQ-032 Read addr 0x01, model slave drives 0x5C in the data byte: MOSI carries 0x00,0x01,0x00; rsp_rdata_o = 0x5C.
REQ-033 Two writes with cmd_valid_i held high, CS_GAP = 2: spi_ncs_o high for exactly 3 cycles between frames; no command lost.
REQ-034 Change cmd_addr_i from 0x03 to 0x7F during a frame: frame still carries address 0x03.
REQ-035 Assert nrst_i low at bit 10: spi_ncs_o = 1 and spi_clk_o = 0 immediately; no rsp_valid_o; a new write succeeds after release.
REQ-036 Protocol checker on every frame: MOSI stable while SCK is high, exactly 24 SCK rising edges per frame, SCK low at both spi_ncs_o edges.
